// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES request scheduler.
package aes_sched_pkg;

  // Block width of the AES core; the result struct is built with this width.
  localparam int DEFAULT_DATA_W = 128;

  // Requester id width (two requesters).
  localparam int SRC_W = 1;

  // One captured core result, tagged with the requester it belongs to.
  typedef struct packed {
    logic [SRC_W-1:0]          src;
    logic [DEFAULT_DATA_W-1:0] data;
  } result_t;

  // One stage of the in-flight tag delay line.
  typedef struct packed {
    logic             valid;
    logic [SRC_W-1:0] src;
  } tag_t;

endpackage

// File: rtl/aes_sched_fifo.sv
// Synchronous FIFO of tagged AES results. Pointers carry an extra wrap bit so
// full and empty are told apart without a separate counter register.
module aes_sched_fifo
  import aes_sched_pkg::*;
#(
  parameter int  DEPTH = 16,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  result_t       wdata,
  input  logic          pop,
  output result_t       rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          wr_wrap;
  logic          rd_wrap;
  logic          do_push;
  logic          do_pop;
  result_t       mem [DEPTH];

  // Step an index through 0..DEPTH-1, toggling the wrap bit on rollover.
  function automatic logic [AW:0] advance(input logic [AW-1:0] idx, input logic wrap);
    if (idx == AW'(DEPTH - 1)) return {~wrap, AW'(0)};
    else                       return {wrap, idx + AW'(1)};
  endfunction

  assign empty = (wr_idx == rd_idx) && (wr_wrap == rd_wrap);
  assign full  = (wr_idx == rd_idx) && (wr_wrap != rd_wrap);

  // A pop frees the head slot at the same edge, so push+pop is legal when full.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Advance read and write pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      wr_idx  <= '0;
      wr_wrap <= 1'b0;
      rd_idx  <= '0;
      rd_wrap <= 1'b0;
    end else begin
      if (do_push) {wr_wrap, wr_idx} <= advance(wr_idx, wr_wrap);
      if (do_pop)  {rd_wrap, rd_idx} <= advance(rd_idx, rd_wrap);
    end
  end

  // Write the storage array.
  // NOTE: the data array has no reset; pointers alone define which entries
  // are live, and resetting wide storage would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= wdata;
  end

  assign rdata = mem[rd_idx];

  // Derive the fill level from the pointer pair.
  always_comb begin
    // NOTE: default assigned first so no path leaves count unassigned (no latch).
    count = '0;
    if (wr_wrap == rd_wrap) count = CW'(wr_idx) - CW'(rd_idx);
    else                    count = CW'(DEPTH) - CW'(rd_idx) + CW'(wr_idx);
  end

  // A push into a full FIFO without a simultaneous pop would drop a result.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop))
    else $error("aes_sched_fifo: push while full");

endmodule

// File: rtl/aes_req_scheduler.sv
// Shares one fixed-latency AES core between two requesters: round-robin grant,
// registered core input, source-tag delay line, and a credit-limited result
// FIFO returned on a tagged valid/ready stream.
module aes_req_scheduler
  import aes_sched_pkg::*;
#(
  parameter int  DATA_W    = DEFAULT_DATA_W,  // must equal DEFAULT_DATA_W
  parameter int  LATENCY   = 10,              // 1..64
  parameter int  OUT_DEPTH = 16,              // >= 1
  localparam int OCC_W     = $clog2(OUT_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [DATA_W-1:0] s1_data,
  output logic [DATA_W-1:0] core_in,
  input  logic [DATA_W-1:0] core_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_src,
  output logic [OCC_W-1:0]  occupancy
);

  logic             grant0;
  logic             grant1;
  logic             issue;
  logic             grant_id;
  logic             last_grant;
  logic             can_issue;
  logic             pop;
  tag_t             tag_line [LATENCY];
  result_t          fifo_wdata;
  result_t          fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [OCC_W-1:0] fifo_count;

  // Credits cover both in-flight and buffered blocks, so the FIFO can never
  // be asked to hold more than it has room for.
  assign can_issue = occupancy < OCC_W'(OUT_DEPTH);

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (can_issue) begin
      if (s0_valid && s1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = s0_valid;
        grant1 = s1_valid;
      end
    end
  end

  assign issue    = grant0 || grant1;
  assign grant_id = grant1;
  assign s0_ready = grant0;
  assign s1_ready = grant1;

  // Load the core input register and remember who was served; last_grant
  // resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_in    <= '0;
      last_grant <= 1'b1;
    end else if (issue) begin
      core_in    <= grant_id ? s1_data : s0_data;
      last_grant <= grant_id;
    end
  end

  // Tag delay line: shifts every cycle, matching the core's fixed latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) tag_line[i] <= '0;
    end else begin
      tag_line[0] <= '{valid: issue, src: grant_id};
      for (int i = 1; i < LATENCY; i++) tag_line[i] <= tag_line[i-1];
    end
  end

  assign fifo_wdata = '{src: tag_line[LATENCY-1].src, data: core_out};
  assign pop        = m_valid && m_ready;

  aes_sched_fifo #(
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tag_line[LATENCY-1].valid),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Credit counter: +1 per issue, -1 per delivered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else begin
      case ({issue, pop})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Head of FIFO is presented directly; outputs read as zero while empty.
  assign m_valid = !fifo_empty;
  assign m_data  = fifo_empty ? '0 : fifo_rdata.data;
  assign m_src   = fifo_empty ? 1'b0 : fifo_rdata.src[0];

  // Buffered results are a subset of the credits in use.
  assert property (@(posedge clk) disable iff (!rst_n)
    (occupancy <= OCC_W'(OUT_DEPTH)) && (fifo_count <= occupancy))
    else $error("aes_req_scheduler: occupancy out of range");

  assert property (@(posedge clk) disable iff (!rst_n)
    fifo_full |-> (occupancy == OCC_W'(OUT_DEPTH)))
    else $error("aes_req_scheduler: FIFO full without all credits used");

endmodule
